// File: rtl/mic_volume_meter_if.sv
// mic_volume_meter_if
// Groups the sample input and the volume outputs of mic_volume_meter.
//   sample_valid : one-cycle strobe, mic_in is valid this cycle
//   mic_in       : 12-bit unsigned mic sample
//   vol          : latched volume level, 0..MAX_VOL
//   vol_valid    : one-cycle pulse when vol/peak are updated
//   noisy        : debounced noisy flag
//   peak         : raw peak of the last completed window
// master = sample producer / display consumer side, slave = the meter.
interface mic_volume_meter_if;
  logic        sample_valid;
  logic [11:0] mic_in;
  logic [4:0]  vol;
  logic        vol_valid;
  logic        noisy;
  logic [11:0] peak;

  modport master (
    output sample_valid, mic_in,
    input  vol, vol_valid, noisy, peak
  );

  modport slave (
    input  sample_valid, mic_in,
    output vol, vol_valid, noisy, peak
  );
endinterface

// File: rtl/mic_volume_meter.sv
// mic_volume_meter
// Turns raw 12-bit mic samples into a windowed peak, a quantised 5-bit
// volume level and a hysteresis-debounced noisy flag.
//   basys_clock : system clock, rising edge
//   reset       : asynchronous, active-high
//   bus         : mic_volume_meter_if.slave (samples in, level/flag out)
//
// state    | meaning
// ST_QUIET | counting consecutive loud windows toward NOISY
// ST_NOISY | counting consecutive quiet windows toward QUIET
module mic_volume_meter #(
  parameter int WINDOW        = 4000,
  parameter int BASELINE      = 2048,
  parameter int STEP_SHIFT    = 7,
  parameter int MAX_VOL       = 15,
  parameter int LOUD_TH       = 10,
  parameter int QUIET_TH      = 6,
  parameter int ENTER_WINDOWS = 3,
  parameter int EXIT_WINDOWS  = 5
) (
  input  logic                basys_clock,
  input  logic                reset,
  mic_volume_meter_if.slave   bus
);

  localparam int CNT_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam int LW    = $clog2(ENTER_WINDOWS + 1);
  localparam int QW    = $clog2(EXIT_WINDOWS + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);
  localparam logic [11:0]      BASE_C   = 12'(BASELINE);
  localparam logic [11:0]      MAXV_C   = 12'(MAX_VOL);
  localparam logic [4:0]       LOUD_C   = 5'(LOUD_TH);
  localparam logic [4:0]       QUIET_C  = 5'(QUIET_TH);
  localparam logic [LW-1:0]    ENTER_M1 = LW'(ENTER_WINDOWS - 1);
  localparam logic [QW-1:0]    EXIT_M1  = QW'(EXIT_WINDOWS - 1);

  typedef enum logic {ST_QUIET, ST_NOISY} state_t;

  // window datapath
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [11:0]      run_max_q, run_max_d;
  logic [11:0]      peak_q, peak_d;
  logic [4:0]       vol_q, vol_d;
  logic             vol_valid_q, vol_valid_d;

  logic [11:0]      window_peak;
  logic [11:0]      diff;
  logic [11:0]      shifted;
  logic [4:0]       vol_calc;

  // hysteresis FSM
  state_t           state_q;
  logic [LW-1:0]    loud_cnt_q;
  logic [QW-1:0]    quiet_cnt_q;
  logic             noisy_q;

  // The closing sample takes part in the peak, so the max is formed
  // combinationally with the incoming sample.
  always_comb begin
    window_peak = (bus.mic_in > run_max_q) ? bus.mic_in : run_max_q;
    diff        = window_peak - BASE_C;
    shifted     = diff >> STEP_SHIFT;
    // Clamp in 12 bits before narrowing so large shifts cannot alias.
    if (window_peak <= BASE_C)  vol_calc = 5'd0;
    else if (shifted > MAXV_C)  vol_calc = MAXV_C[4:0];
    else                        vol_calc = shifted[4:0];
  end

  always_comb begin
    cnt_d       = cnt_q;
    run_max_d   = run_max_q;
    peak_d      = peak_q;
    vol_d       = vol_q;
    vol_valid_d = 1'b0;
    if (bus.sample_valid) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d       = '0;
        run_max_d   = '0;
        peak_d      = window_peak;
        vol_d       = vol_calc;
        vol_valid_d = 1'b1;
      end else begin
        cnt_d     = cnt_q + 1'b1;
        run_max_d = window_peak;
      end
    end
  end

  always_ff @(posedge basys_clock or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      run_max_q   <= '0;
      peak_q      <= '0;
      vol_q       <= '0;
      vol_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      run_max_q   <= run_max_d;
      peak_q      <= peak_d;
      vol_q       <= vol_d;
      vol_valid_q <= vol_valid_d;
    end
  end

  // Evaluated on the vol_valid cycle with the freshly latched vol.
  // Reaching a streak target transitions and clears both streaks, so the
  // counters never pass their targets.
  always_ff @(posedge basys_clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_QUIET;
      loud_cnt_q  <= '0;
      quiet_cnt_q <= '0;
      noisy_q     <= 1'b0;
    end else if (vol_valid_q) begin
      case (state_q)
        ST_QUIET: begin
          if (vol_q >= LOUD_C) begin
            if (loud_cnt_q >= ENTER_M1) begin
              state_q     <= ST_NOISY;
              noisy_q     <= 1'b1;
              loud_cnt_q  <= '0;
              quiet_cnt_q <= '0;
            end else begin
              loud_cnt_q <= loud_cnt_q + 1'b1;
            end
          end else begin
            loud_cnt_q <= '0;
          end
        end
        ST_NOISY: begin
          if (vol_q < QUIET_C) begin
            if (quiet_cnt_q >= EXIT_M1) begin
              state_q     <= ST_QUIET;
              noisy_q     <= 1'b0;
              loud_cnt_q  <= '0;
              quiet_cnt_q <= '0;
            end else begin
              quiet_cnt_q <= quiet_cnt_q + 1'b1;
            end
          end else begin
            quiet_cnt_q <= '0;
          end
        end
        default: begin
          state_q     <= ST_QUIET;
          noisy_q     <= 1'b0;
          loud_cnt_q  <= '0;
          quiet_cnt_q <= '0;
        end
      endcase
    end
  end

  assign bus.vol       = vol_q;
  assign bus.vol_valid = vol_valid_q;
  assign bus.noisy     = noisy_q;
  assign bus.peak      = peak_q;

endmodule

// File: tb/tb_mic_volume_meter.sv
// tb_mic_volume_meter
// Directed and randomized checks of mic_volume_meter (WINDOW=4) against a
// reference model built from window sample lists and level histories.
module tb_mic_volume_meter;
  localparam int WIN = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mic_volume_meter_if bus ();

  mic_volume_meter #(.WINDOW(WIN)) dut (
    .basys_clock (clk),
    .reset       (rst),
    .bus         (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // reference model
  int win_q[$];
  int lvl_hist[$];
  bit m_noisy  = 0;
  int exp_peak = 0;
  int exp_vol  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int level_of(input int pk);
    int v;
    if (pk <= 2048) return 0;
    v = (pk - 2048) / 128;
    return (v > 15) ? 15 : v;
  endfunction

  // Noisy when the last 3 levels since the last transition are all loud;
  // quiet again when the last 5 since the last transition are all quiet.
  function automatic void fsm_update(input int lvl);
    bit all_ok;
    int n;
    lvl_hist.push_back(lvl);
    n = m_noisy ? 5 : 3;
    if (lvl_hist.size() >= n) begin
      all_ok = 1;
      for (int i = lvl_hist.size() - n; i < lvl_hist.size(); i++)
        if (m_noisy ? (lvl_hist[i] >= 6) : (lvl_hist[i] < 10)) all_ok = 0;
      if (all_ok) begin
        m_noisy = !m_noisy;
        lvl_hist.delete();
      end
    end
  endfunction

  function automatic int max_of_window();
    int pk = 0;
    foreach (win_q[i]) if (win_q[i] > pk) pk = win_q[i];
    return pk;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    win_q.delete();
    lvl_hist.delete();
    m_noisy  = 0;
    exp_peak = 0;
    exp_vol  = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send(input int v, input int gap);
    int pk, lvl;
    @(negedge clk);
    bus.sample_valid = 1'b1;
    bus.mic_in       = 12'(v);
    @(negedge clk);
    bus.sample_valid = 1'b0;
    win_q.push_back(v);
    if (win_q.size() == WIN) begin
      pk = max_of_window();
      win_q.delete();
      lvl      = level_of(pk);
      exp_peak = pk;
      exp_vol  = lvl;
      chk("vol_valid_pulse", bus.vol_valid, 1);
      chk("peak", bus.peak, pk);
      chk("vol", bus.vol, lvl);
      chk("noisy_before_eval", bus.noisy, m_noisy);
      fsm_update(lvl);
    end else begin
      chk("vol_valid_idle", bus.vol_valid, 0);
      chk("peak_hold_mid", bus.peak, exp_peak);
    end
    @(negedge clk);
    chk("vol_valid_drop", bus.vol_valid, 0);
    chk("noisy", bus.noisy, m_noisy);
    chk("vol_hold", bus.vol, exp_vol);
    repeat (gap) @(negedge clk);
  endtask

  // One window whose peak lands in the requested level.
  task automatic window_level(input int lvl);
    int pos, pkv;
    pos = $urandom_range(0, WIN - 1);
    if (lvl == 0) pkv = $urandom_range(0, 2048);
    else          pkv = 2048 + lvl * 128 + $urandom_range(0, 127);
    for (int i = 0; i < WIN; i++)
      send((i == pos) ? pkv : $urandom_range(0, pkv), $urandom_range(0, 2));
  endtask

  int entry_lv[6] = '{12, 12, 8, 12, 12, 12};
  int exit_lv[10] = '{3, 3, 3, 3, 7, 3, 3, 3, 3, 3};
  int vals[8];
  int pulses[$];
  int pk2, lv2;

  initial begin
    bus.sample_valid = 1'b0;
    bus.mic_in       = '0;

    // reset state
    do_reset();
    chk("rst_vol", bus.vol, 0);
    chk("rst_vol_valid", bus.vol_valid, 0);
    chk("rst_noisy", bus.noisy, 0);
    chk("rst_peak", bus.peak, 0);

    // reset mid-window discards the partial window
    send(4000, 0);
    send(4000, 0);
    do_reset();
    chk("midrst_peak", bus.peak, 0);
    for (int i = 0; i < 4; i++) send(2000, 0);
    chk("midrst_final_peak", bus.peak, 2000);
    chk("midrst_final_noisy", bus.noisy, 0);

    // peak and latency with idle gaps
    send(2100, 3);
    send(3000, 3);
    send(2500, 3);
    send(2200, 3);
    chk("lat_vol7", bus.vol, 7);

    // closing sample carries the peak; saturation; silence
    send(2048, 0);
    send(2048, 0);
    send(2048, 0);
    send(4095, 0);
    chk("sat_vol15", bus.vol, 15);
    for (int i = 0; i < 4; i++) send(1000, 1);
    chk("quiet_vol0", bus.vol, 0);

    // noisy entry with a broken streak
    foreach (entry_lv[i]) begin
      window_level(entry_lv[i]);
      if (i < 5) chk("entry_still_quiet", bus.noisy, 0);
    end
    chk("entry_noisy", bus.noisy, 1);

    // noisy exit through the hysteresis band
    foreach (exit_lv[i]) begin
      window_level(exit_lv[i]);
      if (i < 9) chk("exit_still_noisy", bus.noisy, 1);
    end
    chk("exit_quiet", bus.noisy, 0);

    // random level sequence
    for (int w = 0; w < 24; w++) begin
      if ($urandom_range(0, 1) == 1) window_level($urandom_range(10, 15));
      else                           window_level($urandom_range(0, 15));
    end

    // back-to-back strobes: two windows, no dead cycle
    foreach (vals[i]) vals[i] = $urandom_range(0, 4095);
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (bus.vol_valid === 1'b1) pulses.push_back(i);
      if (i == 4 || i == 8) begin
        pk2 = 0;
        for (int j = i - 4; j < i; j++) if (vals[j] > pk2) pk2 = vals[j];
        lv2 = level_of(pk2);
        chk("b2b_peak", bus.peak, pk2);
        chk("b2b_vol", bus.vol, lv2);
        fsm_update(lv2);
        exp_peak = pk2;
        exp_vol  = lv2;
      end
      if (i < 8) begin
        bus.sample_valid = 1'b1;
        bus.mic_in       = 12'(vals[i]);
      end else begin
        bus.sample_valid = 1'b0;
      end
    end
    chk("b2b_pulse_count", pulses.size(), 2);
    if (pulses.size() == 2) chk("b2b_pulse_gap", pulses[1] - pulses[0], 4);
    @(negedge clk);
    chk("b2b_noisy", bus.noisy, m_noisy);
    chk("b2b_vol_valid_drop", bus.vol_valid, 0);

    // one more window to confirm the counter restarted cleanly
    window_level($urandom_range(0, 15));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
